vend_input_arbiter: RTL

Front-end sequencer for the vending machine controller. Synchronizes the raw coin buttons and drink-select switches, edge-detects them, and queues each press as a pending request. It then issues the requests to the controller as single-cycle one-hot pulses, one at a time. Pulses are spaced so that every request is seen by the controller's registered state, and none is issued while the controller is dispensing.

---
 rtl/vend_input_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/vend_input_arbiter.sv
// vend_input_arbiter: synchronizes, edge-detects and queues coin/select presses, issuing them as spaced one-hot pulses.
// Optional per-line debounce is enabled with VEND_ARB_DEBOUNCE_EN.
module vend_input_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int DB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [2:0] btn_raw,
  input  logic [3:0] sel_raw,
  input  logic       busy,
  output logic [2:0] coin_pulse,
  output logic [3:0] sel_pulse,
  output logic [6:0] pending,
  output logic [7:0] drop_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_param
    $error("vend_input_arbiter: parameter out of range");
  end

  logic [6:0] s1_q, s2_q, prev_q, pend_q, pend_d, pulse_q, lvl, edg, clr, drops, masked, gnt;
  logic [7:0] drop_q, drop_d;
  logic [8:0] dsum;
  logic [3:0] gap_q, gap_d, nd;
  logic [0:0] state_q, state_d;
  logic       rr_q, rr_d, pick_sel, issue;

`ifdef VEND_ARB_DEBOUNCE_EN
  logic [6:0] db_q;
  for (genvar i = 0; i < 7; i++) begin : g_db
    logic [7:0] cnt_q;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        cnt_q   <= '0;
        db_q[i] <= 1'b0;
      end else if (s2_q[i] == db_q[i]) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        db_q[i] <= s2_q[i];
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
  assign lvl = db_q;
`else
  assign lvl = s2_q;
`endif

  assign edg = lvl & ~prev_q;

  // Round-robin between groups, then lowest index wins inside the chosen group
  always_comb begin
    pick_sel = |pend_q[6:3] && (rr_q || ~|pend_q[2:0]);
    masked   = pick_sel ? {pend_q[6:3], 3'b000} : {4'b0000, pend_q[2:0]};
    gnt      = masked & (~masked + 7'd1);
    issue    = state_q == IDLE && !busy && |pend_q;
    clr      = issue ? gnt : 7'd0;
    pend_d   = (pend_q & ~clr) | edg;
    drops    = edg & pend_q & ~clr;
    nd       = '0;
    for (int i = 0; i < 7; i++) nd = nd + 4'(drops[i]);
    dsum     = {1'b0, drop_q} + 9'(nd);
    drop_d   = dsum[8] ? 8'hff : dsum[7:0];
    state_d  = issue ? GAP : (state_q == GAP && gap_q == 4'd1) ? IDLE : state_q;
    gap_d    = issue ? 4'(GAP_CYCLES) : state_q == GAP ? gap_q - 4'd1 : gap_q;
    rr_d     = issue ? ~pick_sel : rr_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      pulse_q <= '0;
      drop_q  <= '0;
      gap_q   <= '0;
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      s1_q    <= {sel_raw, btn_raw};
      s2_q    <= s1_q;
      prev_q  <= lvl;
      pend_q  <= pend_d;
      pulse_q <= clr;
      drop_q  <= drop_d;
      gap_q   <= gap_d;
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  assign coin_pulse = pulse_q[2:0];
  assign sel_pulse  = pulse_q[6:3];
  assign pending    = pend_q;
  assign drop_cnt   = drop_q;
endmodule
